// File: rtl/lpif_txrx_pkg.sv
// Field layout of the LPIF FIFO word, packed LSB-first as
// state, protid, data, dvalid, crc, crc_valid, valid.
package lpif_txrx_pkg;

    localparam int STATE_W    = 4;
    localparam int PROTID_W   = 2;
    localparam int OFF_STATE  = 0;
    localparam int OFF_PROTID = OFF_STATE + STATE_W;
    localparam int OFF_DATA   = OFF_PROTID + PROTID_W;
    localparam int DEF_LANES  = 8;

    function automatic int data_w(input int lanes);
        return lanes * 64;
    endfunction

    function automatic int crc_w(input int lanes);
        return lanes * 2;
    endfunction

    function automatic int fifo_w(input int lanes);
        return data_w(lanes) + crc_w(lanes) + 9;
    endfunction

    function automatic int off_dvalid(input int lanes);
        return OFF_DATA + data_w(lanes);
    endfunction

    function automatic int off_crc(input int lanes);
        return off_dvalid(lanes) + 1;
    endfunction

    function automatic int off_crc_valid(input int lanes);
        return off_crc(lanes) + crc_w(lanes);
    endfunction

    function automatic int off_valid(input int lanes);
        return off_crc_valid(lanes) + 1;
    endfunction

    // Packed word for the default channel count; members listed MSB first.
    typedef struct packed {
        logic                            valid;
        logic                            crc_valid;
        logic [crc_w(DEF_LANES)-1:0]     crc;
        logic                            dvalid;
        logic [data_w(DEF_LANES)-1:0]    data;
        logic [PROTID_W-1:0]             protid;
        logic [STATE_W-1:0]              state;
    } lpif_word_t;

endpackage

// File: rtl/lpif_skid2.sv
// Two-entry skid buffer with registered ready; head entry is always the output.
module lpif_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [1:0]       count_q, count_d;
    logic             ready_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    assign push        = in_valid_i & ready_q;
    assign pop         = out_valid_o & out_ready_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign in_ready_o  = ready_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready is low at count 2, so push never coincides with a full buffer.
        if (push && (count_q == 2'd0 || (pop && count_q == 2'd1))) begin
            head_d = in_data_i;
        end else if (pop && count_q == 2'd2) begin
            head_d = tail_q;
        end
        if (push && !pop && count_q == 2'd1) begin
            tail_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d < 2'd2);
        end
    end

    always_ff @(posedge clk_i) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

endmodule

// File: rtl/lpif_txrx_slave_param.sv
// LPIF slave adapter: upstream words go through a 2-entry skid buffer to the TX FIFO,
// downstream FIFO words are registered onto the dstrm_* outputs.
module lpif_txrx_slave_param
    import lpif_txrx_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic                          clk_wr,
    input  logic                          rst_wr_n,
    input  logic                          m_gen2_mode,
    input  logic [3:0]                    ustrm_state,
    input  logic [1:0]                    ustrm_protid,
    input  logic [LANES*64-1:0]           ustrm_data,
    input  logic                          ustrm_dvalid,
    input  logic [LANES*2-1:0]            ustrm_crc,
    input  logic                          ustrm_crc_valid,
    input  logic                          ustrm_valid,
    output logic                          ustrm_ready,
    output logic [LANES*64+LANES*2+8:0]   txfifo_upstream_data,
    output logic                          txfifo_upstream_vld,
    input  logic                          txfifo_upstream_ready,
    input  logic [LANES*64+LANES*2+8:0]   rxfifo_downstream_data,
    input  logic                          rxfifo_downstream_vld,
    output logic [3:0]                    dstrm_state,
    output logic [1:0]                    dstrm_protid,
    output logic [LANES*64-1:0]           dstrm_data,
    output logic                          dstrm_dvalid,
    output logic [LANES*2-1:0]            dstrm_crc,
    output logic                          dstrm_crc_valid,
    output logic                          dstrm_valid,
    output logic [15:0]                   ustrm_word_cnt,
    output logic [15:0]                   dstrm_word_cnt
);

    localparam int DATA_W = data_w(LANES);
    localparam int CRC_W  = crc_w(LANES);
    localparam int FIFO_W = fifo_w(LANES);
    localparam int O_DV   = off_dvalid(LANES);
    localparam int O_CRC  = off_crc(LANES);
    localparam int O_CV   = off_crc_valid(LANES);
    localparam int O_V    = off_valid(LANES);

    localparam logic [DATA_W-1:0] DATA_LO_MASK = {{(DATA_W/2){1'b0}}, {(DATA_W/2){1'b1}}};
    localparam logic [CRC_W-1:0]  CRC_LO_MASK  = {{(CRC_W/2){1'b0}}, {(CRC_W/2){1'b1}}};

    logic [DATA_W-1:0] up_data_m;
    logic [CRC_W-1:0]  up_crc_m;
    logic [FIFO_W-1:0] up_word;
    logic              up_pop;

    // Gen1 masking happens before the buffer, so already-queued words keep their width.
    assign up_data_m = m_gen2_mode ? ustrm_data : (ustrm_data & DATA_LO_MASK);
    assign up_crc_m  = m_gen2_mode ? ustrm_crc  : (ustrm_crc  & CRC_LO_MASK);
    assign up_word   = {ustrm_valid, ustrm_crc_valid, up_crc_m, ustrm_dvalid,
                        up_data_m, ustrm_protid, ustrm_state};

    lpif_skid2 #(.WIDTH(FIFO_W)) u_skid (
        .clk_i       (clk_wr),
        .rst_n_i     (rst_wr_n),
        .in_data_i   (up_word),
        .in_valid_i  (ustrm_valid),
        .in_ready_o  (ustrm_ready),
        .out_data_o  (txfifo_upstream_data),
        .out_valid_o (txfifo_upstream_vld),
        .out_ready_i (txfifo_upstream_ready)
    );

    assign up_pop = txfifo_upstream_vld & txfifo_upstream_ready;

    logic [3:0]        dstrm_state_q;
    logic [1:0]        dstrm_protid_q;
    logic [DATA_W-1:0] dstrm_data_q;
    logic [CRC_W-1:0]  dstrm_crc_q;
    logic              dstrm_dvalid_q, dstrm_crc_valid_q, dstrm_valid_q;
    logic [15:0]       ustrm_cnt_q, dstrm_cnt_q;
    logic [DATA_W-1:0] rx_data;
    logic [CRC_W-1:0]  rx_crc;

    assign rx_data = rxfifo_downstream_data[OFF_DATA +: DATA_W];
    assign rx_crc  = rxfifo_downstream_data[O_CRC +: CRC_W];

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            dstrm_state_q     <= '0;
            dstrm_protid_q    <= '0;
            dstrm_data_q      <= '0;
            dstrm_crc_q       <= '0;
            dstrm_dvalid_q    <= 1'b0;
            dstrm_crc_valid_q <= 1'b0;
            dstrm_valid_q     <= 1'b0;
            ustrm_cnt_q       <= '0;
            dstrm_cnt_q       <= '0;
        end else begin
            if (rxfifo_downstream_vld) begin
                dstrm_state_q     <= rxfifo_downstream_data[OFF_STATE +: STATE_W];
                dstrm_protid_q    <= rxfifo_downstream_data[OFF_PROTID +: PROTID_W];
                dstrm_data_q      <= m_gen2_mode ? rx_data : (rx_data & DATA_LO_MASK);
                dstrm_crc_q       <= m_gen2_mode ? rx_crc  : (rx_crc  & CRC_LO_MASK);
                dstrm_dvalid_q    <= rxfifo_downstream_data[O_DV];
                dstrm_crc_valid_q <= rxfifo_downstream_data[O_CV];
                dstrm_valid_q     <= rxfifo_downstream_data[O_V];
                if (dstrm_cnt_q != 16'hFFFF) dstrm_cnt_q <= dstrm_cnt_q + 16'd1;
            end else begin
                dstrm_dvalid_q    <= 1'b0;
                dstrm_crc_valid_q <= 1'b0;
                dstrm_valid_q     <= 1'b0;
            end
            if (up_pop && ustrm_cnt_q != 16'hFFFF) ustrm_cnt_q <= ustrm_cnt_q + 16'd1;
        end
    end

    assign dstrm_state     = dstrm_state_q;
    assign dstrm_protid    = dstrm_protid_q;
    assign dstrm_data      = dstrm_data_q;
    assign dstrm_crc       = dstrm_crc_q;
    assign dstrm_dvalid    = dstrm_dvalid_q;
    assign dstrm_crc_valid = dstrm_crc_valid_q;
    assign dstrm_valid     = dstrm_valid_q;
    assign ustrm_word_cnt  = ustrm_cnt_q;
    assign dstrm_word_cnt  = dstrm_cnt_q;

endmodule

// File: tb/tb_lpif_txrx_slave_param.sv
// Bench for lpif_txrx_slave_param: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lpif_txrx_slave_param;

    localparam int LANES = 8;
    localparam int DW    = LANES * 64;
    localparam int CW    = LANES * 2;
    localparam int FW    = DW + CW + 9;

    logic clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    logic          rst_wr_n, m_gen2_mode;
    logic [3:0]    ustrm_state;
    logic [1:0]    ustrm_protid;
    logic [DW-1:0] ustrm_data;
    logic          ustrm_dvalid;
    logic [CW-1:0] ustrm_crc;
    logic          ustrm_crc_valid, ustrm_valid, ustrm_ready;
    logic [FW-1:0] txfifo_upstream_data;
    logic          txfifo_upstream_vld, txfifo_upstream_ready;
    logic [FW-1:0] rxfifo_downstream_data;
    logic          rxfifo_downstream_vld;
    logic [3:0]    dstrm_state;
    logic [1:0]    dstrm_protid;
    logic [DW-1:0] dstrm_data;
    logic          dstrm_dvalid;
    logic [CW-1:0] dstrm_crc;
    logic          dstrm_crc_valid, dstrm_valid;
    logic [15:0]   ustrm_word_cnt, dstrm_word_cnt;

    lpif_txrx_slave_param #(.LANES(LANES)) dut (
        .clk_wr                 (clk_wr),
        .rst_wr_n               (rst_wr_n),
        .m_gen2_mode            (m_gen2_mode),
        .ustrm_state            (ustrm_state),
        .ustrm_protid           (ustrm_protid),
        .ustrm_data             (ustrm_data),
        .ustrm_dvalid           (ustrm_dvalid),
        .ustrm_crc              (ustrm_crc),
        .ustrm_crc_valid        (ustrm_crc_valid),
        .ustrm_valid            (ustrm_valid),
        .ustrm_ready            (ustrm_ready),
        .txfifo_upstream_data   (txfifo_upstream_data),
        .txfifo_upstream_vld    (txfifo_upstream_vld),
        .txfifo_upstream_ready  (txfifo_upstream_ready),
        .rxfifo_downstream_data (rxfifo_downstream_data),
        .rxfifo_downstream_vld  (rxfifo_downstream_vld),
        .dstrm_state            (dstrm_state),
        .dstrm_protid           (dstrm_protid),
        .dstrm_data             (dstrm_data),
        .dstrm_dvalid           (dstrm_dvalid),
        .dstrm_crc              (dstrm_crc),
        .dstrm_crc_valid        (dstrm_crc_valid),
        .dstrm_valid            (dstrm_valid),
        .ustrm_word_cnt         (ustrm_word_cnt),
        .dstrm_word_cnt         (dstrm_word_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack(input logic [3:0] st, input logic [1:0] pid,
                                           input logic [DW-1:0] d, input logic dv,
                                           input logic [CW-1:0] c, input logic cv,
                                           input logic v, input logic gen2);
        if (!gen2) begin
            d[DW-1:DW/2] = '0;
            c[CW-1:CW/2] = '0;
        end
        return {v, cv, c, dv, d, pid, st};
    endfunction

    // Independent literal form of an unmasked word whose fields all derive from k.
    function automatic logic [FW-1:0] lit(input int k);
        logic [DW-1:0] d;
        d = '0;
        d[31:0] = k;
        return {1'b1, 1'b1, 16'(k), 1'b1, d, 2'(k), 4'(k)};
    endfunction

    // Reference model: a queue of packed words and plain field copies of the outputs.
    logic [FW-1:0] mq[$];
    bit            model_on = 0;
    bit            m_ready, m_acc, m_pop;
    logic [15:0]   m_ucnt, m_dcnt;
    logic [3:0]    m_state;
    logic [1:0]    m_pid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_crc;
    logic          m_dv, m_cv, m_v;

    always @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            mq.delete();
            m_ready = 0; m_ucnt = 0; m_dcnt = 0;
            m_state = 0; m_pid = 0; m_data = 0; m_crc = 0;
            m_dv = 0; m_cv = 0; m_v = 0;
            model_on = 1;
        end else if (model_on) begin
            m_acc = ustrm_valid && m_ready;
            m_pop = (mq.size() > 0) && txfifo_upstream_ready;
            if (m_pop) begin
                void'(mq.pop_front());
                if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 1;
            end
            if (m_acc)
                mq.push_back(pack(ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
                                  ustrm_crc, ustrm_crc_valid, ustrm_valid, m_gen2_mode));
            m_ready = (mq.size() < 2);
            if (rxfifo_downstream_vld) begin
                m_state = rxfifo_downstream_data[3:0];
                m_pid   = rxfifo_downstream_data[5:4];
                m_data  = rxfifo_downstream_data[6 +: DW];
                m_dv    = rxfifo_downstream_data[6 + DW];
                m_crc   = rxfifo_downstream_data[7 + DW +: CW];
                m_cv    = rxfifo_downstream_data[7 + DW + CW];
                m_v     = rxfifo_downstream_data[8 + DW + CW];
                if (!m_gen2_mode) begin
                    m_data[DW-1:DW/2] = '0;
                    m_crc[CW-1:CW/2]  = '0;
                end
                if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 1;
            end else begin
                m_dv = 0; m_cv = 0; m_v = 0;
            end
        end
    end

    always @(negedge clk_wr) begin
        if (model_on) begin
            chk("m_ready", ustrm_ready, m_ready);
            chk("m_tx_vld", txfifo_upstream_vld, mq.size() > 0);
            if (mq.size() > 0) chk("m_tx_data", txfifo_upstream_data, mq[0]);
            chk("m_ucnt", ustrm_word_cnt, m_ucnt);
            chk("m_dcnt", dstrm_word_cnt, m_dcnt);
            chk("m_dctl", {dstrm_state, dstrm_protid, dstrm_dvalid, dstrm_crc_valid, dstrm_valid},
                          {m_state, m_pid, m_dv, m_cv, m_v});
            chk("m_ddata", dstrm_data, m_data);
            chk("m_dcrc", dstrm_crc, m_crc);
        end
    end

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic drive_up(input int k);
        ustrm_state = 4'(k); ustrm_protid = 2'(k);
        ustrm_data = '0; ustrm_data[31:0] = k;
        ustrm_dvalid = 1; ustrm_crc = 16'(k); ustrm_crc_valid = 1; ustrm_valid = 1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    int vcnt;

    initial begin
        rst_wr_n = 0; m_gen2_mode = 1;
        ustrm_state = 0; ustrm_protid = 0; ustrm_data = '0; ustrm_dvalid = 0;
        ustrm_crc = '0; ustrm_crc_valid = 0; ustrm_valid = 0;
        txfifo_upstream_ready = 0; rxfifo_downstream_data = '0; rxfifo_downstream_vld = 0;
        repeat (3) step();
        @(negedge clk_wr);
        chk("rst_ready", ustrm_ready, 0);
        chk("rst_tx_vld", txfifo_upstream_vld, 0);
        chk("rst_dvalid", dstrm_valid, 0);
        chk("rst_ucnt", ustrm_word_cnt, 0);
        step(); rst_wr_n = 1;
        step();
        @(negedge clk_wr);
        chk("ready_after_rst", ustrm_ready, 1);

        // One gen2 word with A5 data passes through in one cycle.
        txfifo_upstream_ready = 1;
        ustrm_data = {8{64'hA5A5A5A5A5A5A5A5}}; ustrm_state = 4'h3; ustrm_protid = 2'h2;
        ustrm_dvalid = 1; ustrm_crc = 16'hBEEF; ustrm_crc_valid = 1; ustrm_valid = 1;
        step(); ustrm_valid = 0;
        @(negedge clk_wr);
        chk("a5_vld", txfifo_upstream_vld, 1);
        chk("a5_data", txfifo_upstream_data,
            {1'b1, 1'b1, 16'hBEEF, 1'b1, {8{64'hA5A5A5A5A5A5A5A5}}, 2'h2, 4'h3});
        step();
        @(negedge clk_wr);
        chk("a5_ucnt", ustrm_word_cnt, 16'd1);
        chk("a5_empty", txfifo_upstream_vld, 0);

        // Backpressure: three words offered, two accepted, then in-order drain.
        txfifo_upstream_ready = 0;
        drive_up(1); step(); drive_up(2); step(); drive_up(3); step();
        @(negedge clk_wr);
        chk("bp_ready_low", ustrm_ready, 0);
        chk("bp_head_1", txfifo_upstream_data, lit(1));
        step(); txfifo_upstream_ready = 1;
        step();
        @(negedge clk_wr);
        chk("bp_head_2", txfifo_upstream_data, lit(2));
        step(); ustrm_valid = 0;
        @(negedge clk_wr);
        chk("bp_head_3", txfifo_upstream_data, lit(3));
        step();
        @(negedge clk_wr);
        chk("bp_drained", txfifo_upstream_vld, 0);
        chk("bp_ucnt", ustrm_word_cnt, 16'd4);

        // Gen1 width: upper halves dropped at push.
        m_gen2_mode = 0;
        ustrm_data = '1; ustrm_crc = '1; ustrm_valid = 1;
        step(); ustrm_valid = 0;
        @(negedge clk_wr);
        chk("g1_data_hi", txfifo_upstream_data[6 + DW/2 +: DW/2], '0);
        chk("g1_data_lo", txfifo_upstream_data[6 +: DW/2], {(DW/2){1'b1}});
        chk("g1_crc_hi", txfifo_upstream_data[7 + DW + CW/2 +: CW/2], '0);
        chk("g1_crc_lo", txfifo_upstream_data[7 + DW +: CW/2], 8'hFF);
        step(); m_gen2_mode = 1;

        // Downstream word then 10 idle cycles: single valid pulse, sticky state.
        rxfifo_downstream_data = {1'b1, 1'b1, 16'h1234, 1'b1, 512'hC3, 2'h1, 4'h1};
        rxfifo_downstream_vld = 1;
        step(); rxfifo_downstream_vld = 0;
        vcnt = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_wr);
            vcnt += int'(dstrm_valid);
        end
        chk("ds_pulse_cnt", vcnt, 1);
        chk("ds_state_sticky", dstrm_state, 4'h1);
        chk("ds_data_hold", dstrm_data, 512'hC3);

        // Drive the downstream counter up to saturation.
        rxfifo_downstream_vld = 1;
        for (int i = 0; i < 65532; i++) begin
            rxfifo_downstream_data[3:0] = 4'(i);
            step();
        end
        rxfifo_downstream_vld = 0;
        @(negedge clk_wr);
        chk("sat_pre", dstrm_word_cnt, 16'hFFFD);
        rxfifo_downstream_vld = 1;
        repeat (3) step();
        rxfifo_downstream_vld = 0;
        @(negedge clk_wr);
        chk("sat_ffff", dstrm_word_cnt, 16'hFFFF);
        step();
        @(negedge clk_wr);
        chk("sat_hold", dstrm_word_cnt, 16'hFFFF);

        // Reset with two words buffered.
        txfifo_upstream_ready = 0;
        drive_up(5); step(); drive_up(6); step(); ustrm_valid = 0;
        @(negedge clk_wr);
        chk("rs_buffered", txfifo_upstream_vld, 1);
        step(); rst_wr_n = 0;
        step();
        @(negedge clk_wr);
        chk("rs_ready_low", ustrm_ready, 0);
        chk("rs_vld_low", txfifo_upstream_vld, 0);
        rst_wr_n = 1;
        step();
        @(negedge clk_wr);
        chk("rs_vld", txfifo_upstream_vld, 0);
        chk("rs_ucnt", ustrm_word_cnt, 0);
        chk("rs_dcnt", dstrm_word_cnt, 0);
        chk("rs_ready", ustrm_ready, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step();
            ustrm_valid = ($urandom_range(0, 99) < 60);
            ustrm_state = 4'($urandom); ustrm_protid = 2'($urandom);
            ustrm_data = rnd_data(); ustrm_dvalid = 1'($urandom);
            ustrm_crc = 16'($urandom); ustrm_crc_valid = 1'($urandom);
            txfifo_upstream_ready = ($urandom_range(0, 99) < 70);
            rxfifo_downstream_vld = ($urandom_range(0, 99) < 40);
            rxfifo_downstream_data = {1'($urandom), 16'($urandom), rnd_data(), 6'($urandom)};
            rxfifo_downstream_data[FW-1 -: 3] = 3'($urandom);
            if ($urandom_range(0, 99) < 5) m_gen2_mode = ~m_gen2_mode;
            rst_wr_n = ($urandom_range(0, 199) != 0);
        end
        step(); rst_wr_n = 1; ustrm_valid = 0; rxfifo_downstream_vld = 0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
